// File: rtl/axis_pattern_master_if.sv
// axis_pattern_master_if
//   The tvalid/tready/tdata stream between the pattern master and a stream
//   slave.
//   Ports (modport master): tvalid out, tdata out, tready in.
//   Ports (modport slave):  tvalid in,  tdata in,  tready out.
interface axis_pattern_master_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_pattern_master.sv
// axis_pattern_master
//   AXI4-Stream pattern master. Each start command in IDLE sends `len` beats
//   of incrementing data from `seed`. It inserts `gap` idle cycles after each
//   accepted beat except the last, and pulses `done` when the burst is
//   finished. A start with len=0 produces only a done pulse.
//   Ports:
//     aclk, areset      clock, synchronous active-high reset
//     start/len/seed/gap command, sampled only in IDLE
//     busy              burst in progress (excludes the done cycle)
//     done              single-cycle completion pulse
//     stall_cnt[15:0]   saturating count of tvalid & !tready cycles
//                       (present only with AXIS_PATTERN_MASTER_STALL_CNT_EN)
//     m_axis            stream master (tvalid, tready, tdata)
//   Every output is driven from a flop. tvalid and busy are registered from
//   the next-state decode, so no path runs combinationally from an input
//   to an output.
module axis_pattern_master #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [GAP_WIDTH-1:0]  gap,
    output logic                  busy,
    output logic                  done,
`ifdef AXIS_PATTERN_MASTER_STALL_CNT_EN
    output logic [15:0]           stall_cnt,
`endif
    axis_pattern_master_if.master m_axis
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [GAP_WIDTH-1:0]  gap_len_q, gap_len_d;
    logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
    logic                  tvalid_q, busy_q, done_q, done_d;
    logic                  hs;

    assign hs            = tvalid_q & m_axis.tready;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = data_q;
    assign busy          = busy_q;
    assign done          = done_q;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        data_d    = data_q;
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        rem_d     = len;
                        data_d    = seed;
                        gap_len_d = gap;
                        state_d   = SEND;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (hs) begin
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rem_d  = rem_q - LEN_WIDTH'(1);
                        data_d = data_q + DATA_WIDTH'(1);
                        if (gap_len_q != '0) begin
                            state_d   = GAP;
                            gap_cnt_d = gap_len_q;
                        end
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                // A count of 0 cannot occur here. The <= comparison
                // guarantees that GAP always exits.
                if (gap_cnt_q <= GAP_WIDTH'(1)) state_d = SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            data_q    <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            tvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            data_q    <= data_d;
            gap_len_q <= gap_len_d;
            gap_cnt_q <= gap_cnt_d;
            tvalid_q  <= (state_d == SEND);
            busy_q    <= (state_d != IDLE);
            done_q    <= done_d;
        end
    end

`ifdef AXIS_PATTERN_MASTER_STALL_CNT_EN
    // Any start taken in IDLE clears the counter, including a len=0 start.
    always_ff @(posedge aclk) begin
        if (areset) begin
            stall_cnt <= '0;
        end else if (state_q == IDLE && start) begin
            stall_cnt <= '0;
        end else if (tvalid_q && !m_axis.tready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_pattern_master.sv
// tb_axis_pattern_master
//   Directed and randomized bursts against a reference model. The model
//   expects beat i of a burst to carry (seed + i) mod 256. After each accepted
//   non-final beat it expects exactly `gap` tvalid-low cycles. It expects done
//   one cycle after the last handshake. It counts stalls as valid cycles
//   without ready.
module tb_axis_pattern_master;

    logic        aclk = 1'b0;
    logic        areset;
    logic        start;
    logic [15:0] len;
    logic [7:0]  seed;
    logic [3:0]  gap;
    logic        busy, done;
`ifdef AXIS_PATTERN_MASTER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    axis_pattern_master_if #(.DATA_WIDTH(8)) ax ();

    axis_pattern_master dut (
        .aclk      (aclk),
        .areset    (areset),
        .start     (start),
        .len       (len),
        .seed      (seed),
        .gap       (gap),
        .busy      (busy),
        .done      (done),
`ifdef AXIS_PATTERN_MASTER_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .m_axis    (ax.master)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call this at a negedge. It returns at the negedge of the done cycle,
    // so a further call issues a back-to-back start.
    task automatic run_burst(input int l, input int s, input int g,
                             input int hold0, input bit rnd, input bit noise);
        int         idx = 0, low = 0, stalls = 0, vcnt = 0;
        bit         after_acc = 0, fin = 0, trd;
        logic [7:0] exp_d;
        start = 1'b1; len = 16'(l); seed = 8'(s); gap = 4'(g);
        ax.tready = 1'b0;
        @(posedge aclk); #1 start = 1'b0;
        if (l == 0) begin
            @(negedge aclk);
            chk("len0 done", 32'(done), 1);
            chk("len0 busy", 32'(busy), 0);
            chk("len0 tvalid", 32'(ax.tvalid), 0);
            return;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge aclk);
            if (idx == l) begin
                start = 1'b0;
                chk("done pulse", 32'(done), 1);
                chk("busy end", 32'(busy), 0);
                chk("tvalid end", 32'(ax.tvalid), 0);
`ifdef AXIS_PATTERN_MASTER_STALL_CNT_EN
                chk("stall_cnt", 32'(stall_cnt), 32'(stalls));
`endif
                fin = 1;
                break;
            end
            chk("busy", 32'(busy), 1);
            chk("done early", 32'(done), 0);
            if (ax.tvalid) begin
                exp_d = 8'(s + idx);
                chk("tdata", 32'(ax.tdata), 32'(exp_d));
                if (after_acc) chk("gap length", 32'(low), 32'(g));
                after_acc = 0;
            end else begin
                chk("tvalid low outside gap", 32'(after_acc && low < g), 1);
                low++;
            end
            if (ax.tvalid && vcnt < hold0) trd = 1'b0;
            else trd = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ax.tvalid) vcnt++;
            ax.tready = trd;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                len   = 16'($urandom_range(0, 9));
                seed  = 8'($urandom);
                gap   = 4'($urandom);
            end
            if (ax.tvalid && trd) begin
                idx++; low = 0; after_acc = 1;
            end else if (ax.tvalid) begin
                stalls++;
            end
        end
        if (!fin) chk("burst timeout", 0, 1);
    endtask

    task automatic idle_cycles(input int n);
        start = 1'b0;
        repeat (n) begin
            @(negedge aclk);
            chk("idle done", 32'(done), 0);
            chk("idle tvalid", 32'(ax.tvalid), 0);
            chk("idle busy", 32'(busy), 0);
        end
    endtask

    initial begin
        areset = 1'b1; start = 1'b0; len = '0; seed = '0; gap = '0;
        ax.tready = 1'b1;
        repeat (3) @(negedge aclk);
        chk("rst tvalid", 32'(ax.tvalid), 0);
        chk("rst tdata", 32'(ax.tdata), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
`ifdef AXIS_PATTERN_MASTER_STALL_CNT_EN
        chk("rst stall_cnt", 32'(stall_cnt), 0);
`endif
        areset = 1'b0;
        idle_cycles(2);

        // Basic, wrap, backpressure and gap bursts
        run_burst(4, 8'h10, 0, 0, 0, 0);
        idle_cycles(1);
        run_burst(3, 8'hFE, 0, 0, 0, 0);
        idle_cycles(1);
        run_burst(2, 8'hA0, 0, 5, 0, 0);
        idle_cycles(1);
        run_burst(3, 8'h33, 2, 0, 0, 0);
        idle_cycles(1);

        // len=0 command, then back-to-back bursts with start held mid-burst
        run_burst(0, 8'h55, 0, 0, 0, 0);
        idle_cycles(1);
        run_burst(5, 8'h70, 1, 0, 0, 1);
        run_burst(2, 8'h80, 0, 0, 0, 0);
        idle_cycles(1);

        // Reset during a burst
        start = 1'b1; len = 16'd8; seed = 8'h40; gap = 4'd0; ax.tready = 1'b1;
        @(posedge aclk); #1 start = 1'b0;
        @(negedge aclk);
        chk("rst-mid beat1", 32'(ax.tdata), 32'h40);
        @(negedge aclk);
        chk("rst-mid beat2", 32'(ax.tdata), 32'h41);
        areset = 1'b1;
        @(negedge aclk);
        chk("rst-mid tvalid", 32'(ax.tvalid), 0);
        chk("rst-mid busy", 32'(busy), 0);
        chk("rst-mid done", 32'(done), 0);
        areset = 1'b0;
        idle_cycles(2);
        run_burst(3, 8'h00, 0, 0, 0, 0);
        idle_cycles(1);

        // Randomized bursts with random backpressure and mid-burst noise
        for (int i = 0; i < 25; i++) begin
            run_burst($urandom_range(0, 20), $urandom_range(0, 255),
                      $urandom_range(0, 3), $urandom_range(0, 3), 1, 1);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
